// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: ID/WB/flush descriptor bundle feeding the register hazard scoreboard.
// master drives the ID descriptor, WB commit and flush; slave returns stall, sb_idle, sb_error.
// Carries no state; clk and rst stay plain ports on the modules that use it.
interface reg_scoreboard_if;
  logic       id_valid;
  logic       id_issue;
  logic       id_is_load;
  logic       reg_read_en_1;
  logic       reg_read_en_2;
  logic [4:0] reg_addr_1;
  logic [4:0] reg_addr_2;
  logic       reg_write_en;
  logic [4:0] reg_write_addr;
  logic       wb_write_en;
  logic [4:0] wb_write_addr;
  logic       flush;
  logic       stall;
  logic       sb_idle;
  logic       sb_error;

  modport master (
    output id_valid, id_issue, id_is_load,
    output reg_read_en_1, reg_read_en_2, reg_addr_1, reg_addr_2,
    output reg_write_en, reg_write_addr,
    output wb_write_en, wb_write_addr, flush,
    input  stall, sb_idle, sb_error
  );

  modport slave (
    input  id_valid, id_issue, id_is_load,
    input  reg_read_en_1, reg_read_en_2, reg_addr_1, reg_addr_2,
    input  reg_write_en, reg_write_addr,
    input  wb_write_en, wb_write_addr, flush,
    output stall, sb_idle, sb_error
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: decode-stage GPR hazard scoreboard tracking in-flight destinations from ID issue to WB commit.
// Latency: stall is combinational from ID/WB inputs and current state; counters, sb_idle, sb_error update next edge.
// Backpressure: stall holds IF/ID; an issue raised together with stall is ignored. Optional build macro: SB_FORWARD_EN.
//
// Ports: clk, rst (async, active-high); sb (reg_scoreboard_if.slave) carrying the ID source/dest
// descriptors, WB commit, CP0 flush, and the stall / sb_idle / sb_error outputs.
// SB_FORWARD_EN defined: only the load-use case blocks (EX/MEM forwarding covers everything else);
// counters, sb_idle and sb_error are still maintained for observability and error detection.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Index 0 exists only so a 5-bit address can index directly; it is held at zero.
  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];
  logic             ex_load_valid;
  logic [4:0]       ex_load_addr;
  logic             idle_q;
  logic             error_q;

  logic blk_1, blk_2;
  logic hz_1, hz_2;
  logic stall;
  logic iss, ret;
  logic err_nxt, idle_nxt;

`ifdef SB_FORWARD_EN
  // Forwarding covers every producer except a load whose data is still in MEM next cycle.
  assign blk_1 = ex_load_valid && (ex_load_addr == sb.reg_addr_1);
  assign blk_2 = ex_load_valid && (ex_load_addr == sb.reg_addr_2);
`else
  // A single outstanding write that WB commits this very cycle is visible through the
  // register file's write-through path, so it does not block.
  assign blk_1 = (cnt[sb.reg_addr_1] != '0) &&
                 !((cnt[sb.reg_addr_1] == CNT_ONE) && sb.wb_write_en &&
                   (sb.wb_write_addr == sb.reg_addr_1));
  assign blk_2 = (cnt[sb.reg_addr_2] != '0) &&
                 !((cnt[sb.reg_addr_2] == CNT_ONE) && sb.wb_write_en &&
                   (sb.wb_write_addr == sb.reg_addr_2));
`endif

  assign hz_1  = sb.reg_read_en_1 && (sb.reg_addr_1 != 5'd0) && blk_1;
  assign hz_2  = sb.reg_read_en_2 && (sb.reg_addr_2 != 5'd0) && blk_2;
  assign stall = sb.id_valid && (hz_1 || hz_2);

  assign iss = sb.id_issue && sb.id_valid && !stall && sb.reg_write_en &&
               (sb.reg_write_addr != 5'd0);
  assign ret = sb.wb_write_en && (sb.wb_write_addr != 5'd0);

  always_comb begin
    err_nxt  = 1'b0;
    idle_nxt = 1'b1;
    for (int r = 0; r < 32; r++) begin
      cnt_nxt[r] = cnt[r];
      if (sb.flush || r == 0) begin
        // Flush discards any issue/retire of this cycle, so it can never raise an error.
        cnt_nxt[r] = '0;
      end else begin
        // Issue and retire hitting the same register cancel out.
        if (iss && (sb.reg_write_addr == 5'(r)) &&
            !(ret && (sb.wb_write_addr == 5'(r)))) begin
          if (cnt[r] == CNT_MAX) err_nxt = 1'b1;
          else                   cnt_nxt[r] = cnt[r] + CNT_ONE;
        end
        if (ret && (sb.wb_write_addr == 5'(r)) &&
            !(iss && (sb.reg_write_addr == 5'(r)))) begin
          if (cnt[r] == '0) err_nxt = 1'b1;
          else              cnt_nxt[r] = cnt[r] - CNT_ONE;
        end
      end
      idle_nxt = idle_nxt && (cnt_nxt[r] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
      ex_load_valid <= 1'b0;
      ex_load_addr  <= 5'd0;
      idle_q        <= 1'b1;
      error_q       <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
      // Rewritten every cycle: high for exactly the cycle after a load issues.
      ex_load_valid <= iss && sb.id_is_load && !sb.flush;
      ex_load_addr  <= sb.reg_write_addr;
      idle_q        <= idle_nxt;
      error_q       <= error_q || err_nxt;
    end
  end

  assign sb.stall    = stall;
  assign sb.sb_idle  = idle_q;
  assign sb.sb_error = error_q;

  // A tracked load always targets a real register, since $0 writes never issue.
  ld_addr_nonzero: assert property (@(posedge clk) disable iff (rst)
    ex_load_valid |-> (ex_load_addr != 5'd0));

endmodule
